// File: rtl/mrv1_tw_issue_ctrl.sv
// mrv1_tw_issue_ctrl: per-thread issue state tracking with round-robin thread
// selection. The selection is presented through a registered valid/ready
// handshake. Threads that issue a long-latency op are parked until woken.
// Idle issue cycles are counted while any thread is active.
module mrv1_tw_issue_ctrl #(
  parameter  int NUM_TW_P      = 8,
  localparam int twid_width_lp = $clog2(NUM_TW_P)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_TW_P-1:0]      tw_active_i,
  input  logic [NUM_TW_P-1:0]      tw_rdy_i,
  output logic                     issue_vld_o,
  output logic [twid_width_lp-1:0] issue_twid_o,
  input  logic                     issue_rdy_i,
  input  logic                     issue_long_i,
  input  logic                     wake_vld_i,
  input  logic [twid_width_lp-1:0] wake_twid_i,
  input  logic                     flush_vld_i,
  input  logic [twid_width_lp-1:0] flush_twid_i,
  output logic [31:0]              bubble_cnt_o
);

  typedef enum logic [1:0] {
    TW_IDLE  = 2'd0,
    TW_READY = 2'd1,
    TW_WAIT  = 2'd2
  } tw_state_e;

  tw_state_e                state_q [NUM_TW_P];
  tw_state_e                state_d [NUM_TW_P];
  logic                     vld_q, vld_d;
  logic [twid_width_lp-1:0] twid_q, twid_d;
  logic [twid_width_lp-1:0] rr_q, rr_d;
  logic [31:0]              bubble_q, bubble_d;

  logic                     accept;
  logic                     kill;
  logic                     acc_ok;
  logic [NUM_TW_P-1:0]      elig;
  logic [twid_width_lp-1:0] search_base;
  logic [twid_width_lp-1:0] idx;
  logic [twid_width_lp-1:0] cand_twid;
  logic                     cand_found;

  // A kill (flush or deactivation of the held thread) cancels any acceptance in the same cycle
  assign accept = vld_q & issue_rdy_i;
  assign kill   = vld_q & ((flush_vld_i & (flush_twid_i == twid_q)) | ~tw_active_i[twid_q]);
  assign acc_ok = accept & ~kill;

  // Per-thread next state, earlier branches take priority over later ones
  always_comb begin
    for (int i = 0; i < NUM_TW_P; i++) begin
      state_d[i] = state_q[i];
      if (!tw_active_i[i]) begin
        state_d[i] = TW_IDLE;
      end else if (flush_vld_i && (flush_twid_i == twid_width_lp'(i))) begin
        state_d[i] = TW_READY;
      end else if (acc_ok && issue_long_i && (twid_q == twid_width_lp'(i))) begin
        state_d[i] = TW_WAIT;
      end else if (wake_vld_i && (wake_twid_i == twid_width_lp'(i)) && (state_q[i] == TW_WAIT)) begin
        state_d[i] = TW_READY;
      end else if (state_q[i] == TW_IDLE) begin
        state_d[i] = TW_READY;
      end
    end
  end

  // A thread is eligible when ready, has an instruction, and is not the one currently held
  always_comb begin
    for (int i = 0; i < NUM_TW_P; i++) begin
      elig[i] = (state_q[i] == TW_READY) & tw_rdy_i[i] & ~(vld_q & (twid_q == twid_width_lp'(i)));
    end
  end

  // Round-robin search; after an acceptance it starts just past the accepted thread
  always_comb begin
    search_base = acc_ok ? (twid_q + twid_width_lp'(1)) : rr_q;
    cand_found  = 1'b0;
    cand_twid   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_TW_P; k++) begin
      idx = search_base + twid_width_lp'(k);
      if (!cand_found && elig[idx]) begin
        cand_found = 1'b1;
        cand_twid  = idx;
      end
    end
  end

  // Output register, round-robin pointer and bubble counter next values
  always_comb begin
    vld_d    = vld_q;
    twid_d   = twid_q;
    rr_d     = rr_q;
    bubble_d = bubble_q;
    if (!vld_q || kill) begin
      vld_d = cand_found;
      if (cand_found) twid_d = cand_twid;
    end else if (accept) begin
      rr_d  = twid_q + twid_width_lp'(1);
      vld_d = cand_found;
      if (cand_found) twid_d = cand_twid;
    end
    if (!vld_q && (|tw_active_i)) begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  // Per-thread state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_TW_P; i++) state_q[i] <= TW_IDLE;
    end else begin
      for (int i = 0; i < NUM_TW_P; i++) state_q[i] <= state_d[i];
    end
  end

  // Grant output register, round-robin pointer and bubble counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q    <= 1'b0;
      twid_q   <= '0;
      rr_q     <= '0;
      bubble_q <= '0;
    end else begin
      vld_q    <= vld_d;
      twid_q   <= twid_d;
      rr_q     <= rr_d;
      bubble_q <= bubble_d;
    end
  end

  assign issue_vld_o  = vld_q;
  assign issue_twid_o = twid_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_mrv1_tw_issue_ctrl.sv
// Testbench for mrv1_tw_issue_ctrl. Directed scenarios push the expected grant
// order into a queue; a monitor pops and compares on every accepted grant.
module tb_mrv1_tw_issue_ctrl;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] tw_active;
  logic [N-1:0] tw_rdy;
  logic         issue_vld;
  logic [W-1:0] issue_twid;
  logic         issue_rdy;
  logic         issue_long;
  logic         wake_vld;
  logic [W-1:0] wake_twid;
  logic         flush_vld;
  logic [W-1:0] flush_twid;
  logic [31:0]  bubble_cnt;

  int           testsRun = 0;
  int           testsFailed = 0;
  logic [W-1:0] expQ[$];

  mrv1_tw_issue_ctrl #(.NUM_TW_P(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tw_active_i  (tw_active),
    .tw_rdy_i     (tw_rdy),
    .issue_vld_o  (issue_vld),
    .issue_twid_o (issue_twid),
    .issue_rdy_i  (issue_rdy),
    .issue_long_i (issue_long),
    .wake_vld_i   (wake_vld),
    .wake_twid_i  (wake_twid),
    .flush_vld_i  (flush_vld),
    .flush_twid_i (flush_twid),
    .bubble_cnt_o (bubble_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] act, input logic [N-1:0] rdy,
                               input logic irdy, input logic lng);
    tw_active  = act;
    tw_rdy     = rdy;
    issue_rdy  = irdy;
    issue_long = lng;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    wake_vld   = 1'b0;
    wake_twid  = '0;
    flush_vld  = 1'b0;
    flush_twid = '0;
    applyStimulus('0, '0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_vld", {31'd0, issue_vld}, 32'd0);
    checkOutput("reset_twid", {29'd0, issue_twid}, 32'd0);
    checkOutput("reset_bubble", bubble_cnt, 32'd0);
    rst_n = 1'b1;
  endtask

  // Wait for the scoreboard to empty, bounded; afterwards the caller drops issue_rdy
  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      tick();
      n++;
    end
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain_timeout: %0d grants outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: every non-killed valid&ready offer is a grant and must match the queue head
  always @(negedge clk) begin
    if (rst_n && issue_vld && issue_rdy &&
        !((flush_vld && (flush_twid == issue_twid)) || !tw_active[issue_twid])) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_grant: got twid %0d, expected no grant", issue_twid);
      end else begin
        checkOutput("grant_twid", {29'd0, issue_twid}, {29'd0, expQ.pop_front()});
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Full rotation with everybody active and ready
    doReset();
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    foreach (expQ[i]) expQ.delete();
    expQ = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    tick();
    checkOutput("c1_vld", {31'd0, issue_vld}, 32'd0);
    tick();
    checkOutput("c2_vld", {31'd0, issue_vld}, 32'd1);
    checkOutput("c2_twid", {29'd0, issue_twid}, 32'd0);
    waitDrain(40);
    issue_rdy = 1'b0;
    checkOutput("rot_bubble", bubble_cnt, 32'd2);
    checkOutput("rot_held", {29'd0, issue_twid}, 32'd1);

    // Hold: grant 3 stays put while tw_rdy[3] toggles
    doReset();
    applyStimulus(8'hFF, 8'h08, 1'b0, 1'b0);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      tw_rdy[3] = ~tw_rdy[3];
      tick();
      checkOutput("hold_vld", {31'd0, issue_vld}, 32'd1);
      checkOutput("hold_twid", {29'd0, issue_twid}, 32'd3);
    end
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    expQ.push_back(3'd3);
    waitDrain(10);
    issue_rdy = 1'b0;
    checkOutput("hold_next", {29'd0, issue_twid}, 32'd4);

    // Long op on thread 2: skipped until woken
    doReset();
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    expQ = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd3, 3'd4};
    tick();
    tick();
    tick();
    tick();
    issue_long = 1'b1;
    tick();
    issue_long = 1'b0;
    waitDrain(40);
    issue_rdy = 1'b0;
    checkOutput("long_held", {29'd0, issue_twid}, 32'd5);
    wake_vld  = 1'b1;
    wake_twid = 3'd2;
    tick();
    wake_vld  = 1'b0;
    expQ = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    issue_rdy = 1'b1;
    waitDrain(40);
    issue_rdy = 1'b0;
    checkOutput("wake_held", {29'd0, issue_twid}, 32'd4);

    // Same-cycle wake and long accept of thread 2 leaves it parked
    doReset();
    applyStimulus(8'hFF, 8'h04, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("same_held", {29'd0, issue_twid}, 32'd2);
    expQ.push_back(3'd2);
    issue_rdy  = 1'b1;
    issue_long = 1'b1;
    wake_vld   = 1'b1;
    wake_twid  = 3'd2;
    tick();
    issue_rdy  = 1'b0;
    issue_long = 1'b0;
    wake_vld   = 1'b0;
    checkOutput("same_vld0", {31'd0, issue_vld}, 32'd0);
    tick();
    tick();
    tick();
    checkOutput("same_still_wait", {31'd0, issue_vld}, 32'd0);
    wake_vld = 1'b1;
    tick();
    wake_vld = 1'b0;
    checkOutput("wake_lat1", {31'd0, issue_vld}, 32'd0);
    tick();
    checkOutput("wake_lat2_vld", {31'd0, issue_vld}, 32'd1);
    checkOutput("wake_lat2_twid", {29'd0, issue_twid}, 32'd2);

    // Kill by flush of the held thread
    doReset();
    applyStimulus(8'hFF, 8'h20, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("kill_held", {29'd0, issue_twid}, 32'd5);
    flush_vld  = 1'b1;
    flush_twid = 3'd5;
    tick();
    flush_vld  = 1'b0;
    checkOutput("kill_vld0", {31'd0, issue_vld}, 32'd0);
    tick();
    checkOutput("kill_reload_vld", {31'd0, issue_vld}, 32'd1);
    checkOutput("kill_reload_twid", {29'd0, issue_twid}, 32'd5);
    // Kill overrides a long acceptance; pointer stays at 0 so thread 3 wins
    applyStimulus(8'hFF, 8'h68, 1'b1, 1'b1);
    flush_vld = 1'b1;
    tick();
    flush_vld  = 1'b0;
    issue_long = 1'b0;
    checkOutput("killacc_twid", {29'd0, issue_twid}, 32'd3);
    expQ = '{3'd3, 3'd5, 3'd6};
    waitDrain(20);
    issue_rdy = 1'b0;
    checkOutput("killacc_held", {29'd0, issue_twid}, 32'd3);

    // Kill by deactivating the held thread
    doReset();
    applyStimulus(8'hFF, 8'h20, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(8'hDF, 8'h30, 1'b0, 1'b0);
    tick();
    checkOutput("deact_vld", {31'd0, issue_vld}, 32'd1);
    checkOutput("deact_twid", {29'd0, issue_twid}, 32'd4);
    applyStimulus(8'hDF, 8'h20, 1'b1, 1'b0);
    expQ.push_back(3'd4);
    waitDrain(10);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("deact_never", {31'd0, issue_vld}, 32'd0);
    end
    issue_rdy = 1'b0;

    // Bubble counter with the only active thread parked
    doReset();
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("cnt_start", bubble_cnt, 32'd2);
    expQ.push_back(3'd0);
    issue_rdy  = 1'b1;
    issue_long = 1'b1;
    tick();
    issue_rdy  = 1'b0;
    issue_long = 1'b0;
    checkOutput("cnt_park_vld", {31'd0, issue_vld}, 32'd0);
    repeat (100) tick();
    checkOutput("cnt_100", bubble_cnt, 32'd102);
    wake_vld  = 1'b1;
    wake_twid = 3'd0;
    tick();
    wake_vld = 1'b0;
    checkOutput("cnt_wake1", bubble_cnt, 32'd103);
    tick();
    checkOutput("cnt_wake2_vld", {31'd0, issue_vld}, 32'd1);
    checkOutput("cnt_wake2", bubble_cnt, 32'd104);

    // Counter wrap from a preloaded value
    expQ.push_back(3'd0);
    issue_rdy  = 1'b1;
    issue_long = 1'b1;
    tick();
    issue_rdy  = 1'b0;
    issue_long = 1'b0;
    force dut.bubble_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_q;
    tick();
    checkOutput("wrap_max", bubble_cnt, 32'hFFFF_FFFF);
    tick();
    checkOutput("wrap_zero", bubble_cnt, 32'd0);
    tick();
    checkOutput("wrap_one", bubble_cnt, 32'd1);

    // Asynchronous reset in the middle of a held grant
    wake_vld = 1'b1;
    tick();
    wake_vld = 1'b0;
    tick();
    checkOutput("mid_held_vld", {31'd0, issue_vld}, 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_vld", {31'd0, issue_vld}, 32'd0);
    checkOutput("async_twid", {29'd0, issue_twid}, 32'd0);
    checkOutput("async_bubble", bubble_cnt, 32'd0);

    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
